mioc_dram_seq: RTL and testbench

DRAM strobe sequencer for the MIOC. Converts buffered Z80/DMA memory requests into RAS/MUX/CAS timing for the two 32 KB DRAM banks. Also drives the multiplexed address MSB RA7 and performs RAS-only refresh during Z80 refresh cycles. Sits downstream of the MIOC memory decode, which supplies RAMSEL_N, and drives pins 2 and 37–40 of mioc_top.

---
 rtl/mioc_dram_seq_pkg.sv | 34 +++
 rtl/mioc_dram_seq_if.sv | 49 ++++
 rtl/mioc_dram_seq_cnt.sv | 31 +++
 rtl/mioc_dram_seq.sv | 199 +++++++++++++++++++
 tb/tb_mioc_dram_seq.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mioc_dram_seq_pkg.sv
// mioc_pkg: shared types and constants for the MIOC DRAM strobe sequencer.
//   - dram_state_t : sequencer states (IDLE, ROW, COL, CAS, RFSH, PRE)
//   - CNT_W        : width of the shared TRCD/TRP hold counter
//   - RFCNT_W      : width of the completed-refresh debug counter
//   - TRCD_*/TRP_* : legal ranges for the timing parameters
//   - hold_preload : turns a cycle count into a down-counter preload value
package mioc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        CAS,
        RFSH,
        PRE
    } dram_state_t;

    localparam int CNT_W    = 3;
    localparam int RFCNT_W  = 8;

    localparam int TRCD_MIN = 1;
    localparam int TRCD_MAX = 3;
    localparam int TRP_MIN  = 1;
    localparam int TRP_MAX  = 7;

    // A state held for N cycles loads N-1 and leaves when the count is zero.
    // Out-of-range requests are clamped so the counter can never wrap.
    function automatic logic [CNT_W-1:0] hold_preload(input int cycles, input int lo, input int hi);
        int c;
        c = (cycles < lo) ? lo : ((cycles > hi) ? hi : cycles);
        return CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/mioc_dram_seq_if.sv
// mioc_dram_seq_if: buffered CPU/DMA request bus and DRAM strobe outputs.
//   master modport : request side (drives BMREQ_N..BM1_N, observes strobes)
//   slave modport  : the sequencer (observes requests, drives strobes)
//   Inputs : BMREQ_N, BRFSH_N, BRD_N, N_BWR, RAMSEL_N, BA15, BA7, BA14, BM1_N
//   Outputs: RAS_N, MUX, CAS1_N, CAS2_N, RA7, RFCNT[7:0]
//            WSREQ_N only when MIOC_DRAM_WAIT_EN is defined
interface mioc_dram_seq_if;
    import mioc_pkg::*;

    logic               BMREQ_N;
    logic               BRFSH_N;
    logic               BRD_N;
    logic               N_BWR;
    logic               RAMSEL_N;
    logic               BA15;
    logic               BA7;
    logic               BA14;
    logic               BM1_N;

    logic               RAS_N;
    logic               MUX;
    logic               CAS1_N;
    logic               CAS2_N;
    logic               RA7;
    logic [RFCNT_W-1:0] RFCNT;

`ifdef MIOC_DRAM_WAIT_EN
    logic               WSREQ_N;

    modport master (
        output BMREQ_N, BRFSH_N, BRD_N, N_BWR, RAMSEL_N, BA15, BA7, BA14, BM1_N,
        input  RAS_N, MUX, CAS1_N, CAS2_N, RA7, RFCNT, WSREQ_N
    );
    modport slave (
        input  BMREQ_N, BRFSH_N, BRD_N, N_BWR, RAMSEL_N, BA15, BA7, BA14, BM1_N,
        output RAS_N, MUX, CAS1_N, CAS2_N, RA7, RFCNT, WSREQ_N
    );
`else
    modport master (
        output BMREQ_N, BRFSH_N, BRD_N, N_BWR, RAMSEL_N, BA15, BA7, BA14, BM1_N,
        input  RAS_N, MUX, CAS1_N, CAS2_N, RA7, RFCNT
    );
    modport slave (
        input  BMREQ_N, BRFSH_N, BRD_N, N_BWR, RAMSEL_N, BA15, BA7, BA14, BM1_N,
        output RAS_N, MUX, CAS1_N, CAS2_N, RA7, RFCNT
    );
`endif

endinterface

// File: rtl/mioc_dram_seq_cnt.sv
// mioc_dram_cnt: 3-bit loadable down-counter with zero flag. Shared by the
// row-to-column hold and the precharge hold, which never overlap.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this edge (otherwise count down, stopping at 0)
//   load_val   : preload value
//   count      : current value
//   zero       : count == 0
module mioc_dram_cnt import mioc_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Saturating at zero lets the sequencer treat "zero" as "hold finished"
    // without a separate enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mioc_dram_seq.sv
// mioc_dram_seq: DRAM strobe sequencer for the MIOC. Turns buffered Z80/DMA
// memory requests into RAS/MUX/CAS timing for two 32 KB banks, drives the
// multiplexed RA7 line and performs RAS-only refresh in Z80 refresh cycles.
//   B_PHI : Z80 clock, rising-edge
//   RST_N : asynchronous active-low reset
//   bus   : mioc_dram_seq_if.slave (request inputs, strobe/debug outputs)
// Parameters: TRCD (1-3) RAS-to-MUX cycles, TRP (1-7) precharge cycles.
// Optional: MIOC_DRAM_WAIT_EN adds WSREQ_N and one extra COL cycle for
// opcode fetches (BM1_N low at row start).
module mioc_dram_seq import mioc_pkg::*; #(
    parameter int TRCD = 1,
    parameter int TRP  = 2
) (
    input  logic               B_PHI,
    input  logic               RST_N,
    mioc_dram_seq_if.slave     bus
);

    localparam logic [CNT_W-1:0] TRCD_LOAD = hold_preload(TRCD, TRCD_MIN, TRCD_MAX);
    localparam logic [CNT_W-1:0] TRP_LOAD  = hold_preload(TRP, TRP_MIN, TRP_MAX);

    dram_state_t        state, state_nxt;
    logic               bank, bank_nxt;
    logic               ras_n_q, mux_q, cas1_n_q, cas2_n_q, ra7_q;
    logic               ras_n_nxt, mux_nxt, cas1_n_nxt, cas2_n_nxt, ra7_nxt;
    logic [RFCNT_W-1:0] rfcnt_q;
    logic               rfcnt_inc;
    logic               cnt_load, cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val, cnt_val;
    logic               req, rw;
`ifdef MIOC_DRAM_WAIT_EN
    logic               m1, m1_nxt;
    logic               first_col, first_col_nxt;
    logic               wsreq_n_q, wsreq_n_nxt;
`endif

    assign req = !bus.BMREQ_N;
    assign rw  = !bus.BRD_N || !bus.N_BWR;

    mioc_dram_cnt u_cnt (
        .clk      (B_PHI),
        .rst_n    (RST_N),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // Next state and next output values. Outputs are registered from the
    // state being left, so every strobe lags its state by one edge; a
    // released request overrides this so strobes drop on the release edge.
    always_comb begin
        state_nxt    = state;
        bank_nxt     = bank;
        ras_n_nxt    = 1'b1;
        mux_nxt      = 1'b0;
        cas1_n_nxt   = 1'b1;
        cas2_n_nxt   = 1'b1;
        ra7_nxt      = 1'b0;
        rfcnt_inc    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = TRP_LOAD;
`ifdef MIOC_DRAM_WAIT_EN
        m1_nxt        = m1;
        first_col_nxt = 1'b0;
        wsreq_n_nxt   = 1'b1;
`endif
        unique case (state)
            IDLE: begin
                if (req && cnt_zero && !bus.BRFSH_N) begin
                    state_nxt = RFSH;
                end else if (req && cnt_zero && !bus.RAMSEL_N) begin
                    state_nxt    = ROW;
                    bank_nxt     = bus.BA15;
                    cnt_load     = 1'b1;
                    cnt_load_val = TRCD_LOAD;
`ifdef MIOC_DRAM_WAIT_EN
                    m1_nxt       = !bus.BM1_N;
`endif
                end
            end
            ROW: begin
                if (!req) begin
                    state_nxt = PRE;
                    cnt_load  = 1'b1;
                end else begin
                    ras_n_nxt = 1'b0;
                    ra7_nxt   = bus.BA7;
                    if (cnt_zero) begin
                        state_nxt = COL;
`ifdef MIOC_DRAM_WAIT_EN
                        first_col_nxt = 1'b1;
`endif
                    end
                end
            end
            COL: begin
                if (!req) begin
                    state_nxt = PRE;
                    cnt_load  = 1'b1;
                end else begin
                    ras_n_nxt = 1'b0;
                    mux_nxt   = 1'b1;
                    ra7_nxt   = bus.BA14;
`ifdef MIOC_DRAM_WAIT_EN
                    // Opcode fetches spend their first COL cycle waiting.
                    if (first_col && m1) begin
                        wsreq_n_nxt = 1'b0;
                    end else if (rw) begin
                        state_nxt = CAS;
                    end
`else
                    if (rw) begin
                        state_nxt = CAS;
                    end
`endif
                end
            end
            CAS: begin
                if (!req) begin
                    state_nxt = PRE;
                    cnt_load  = 1'b1;
                end else begin
                    ras_n_nxt  = 1'b0;
                    mux_nxt    = 1'b1;
                    ra7_nxt    = bus.BA14;
                    cas1_n_nxt = bank;
                    cas2_n_nxt = !bank;
                end
            end
            RFSH: begin
                if (!req) begin
                    state_nxt = PRE;
                    cnt_load  = 1'b1;
                    rfcnt_inc = 1'b1;
                end else begin
                    ras_n_nxt = 1'b0;
                    ra7_nxt   = bus.BA7;
                end
            end
            PRE: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, bank latch and registered outputs.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            bank     <= 1'b0;
            ras_n_q  <= 1'b1;
            mux_q    <= 1'b0;
            cas1_n_q <= 1'b1;
            cas2_n_q <= 1'b1;
            ra7_q    <= 1'b0;
            rfcnt_q  <= '0;
        end else begin
            state    <= state_nxt;
            bank     <= bank_nxt;
            ras_n_q  <= ras_n_nxt;
            mux_q    <= mux_nxt;
            cas1_n_q <= cas1_n_nxt;
            cas2_n_q <= cas2_n_nxt;
            ra7_q    <= ra7_nxt;
            if (rfcnt_inc) begin
                rfcnt_q <= rfcnt_q + RFCNT_W'(1);
            end
        end
    end

`ifdef MIOC_DRAM_WAIT_EN
    // Wait-state bookkeeping for opcode fetches.
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            m1        <= 1'b0;
            first_col <= 1'b0;
            wsreq_n_q <= 1'b1;
        end else begin
            m1        <= m1_nxt;
            first_col <= first_col_nxt;
            wsreq_n_q <= wsreq_n_nxt;
        end
    end

    assign bus.WSREQ_N = wsreq_n_q;
`endif

    assign bus.RAS_N  = ras_n_q;
    assign bus.MUX    = mux_q;
    assign bus.CAS1_N = cas1_n_q;
    assign bus.CAS2_N = cas2_n_q;
    assign bus.RA7    = ra7_q;
    assign bus.RFCNT  = rfcnt_q;

endmodule

// File: tb/tb_mioc_dram_seq.sv
// tb_mioc_dram_seq: self-checking bench for mioc_dram_seq (TRCD=1, TRP=2).
// A timeline model predicts every output from the age of the current request
// and the edge at which the bus is next free; a compare process checks it on
// every falling edge. Directed sequences pin the model with literal values,
// then randomized traffic (with occasional async resets) runs against it.
// Honours MIOC_DRAM_WAIT_EN for the WSREQ_N checks.
module tb_mioc_dram_seq;

    localparam int TRCD = 1;
    localparam int TRP  = 2;
`ifdef MIOC_DRAM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic B_PHI;
    logic RST_N;

    mioc_dram_seq_if bus ();

    mioc_dram_seq #(.TRCD(TRCD), .TRP(TRP)) dut (
        .B_PHI (B_PHI),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    initial B_PHI = 1'b0;
    always #5 B_PHI = ~B_PHI;

    // Timeline model state.
    bit     m_acc = 1'b0, m_rfsh = 1'b0, m_bank = 1'b0, m_m1 = 1'b0;
    int     m_age = 0, m_cas_at = -1;
    longint m_edge = 0, m_ready = 0;
    logic       e_ras_n = 1'b1, e_mux = 1'b0, e_cas1_n = 1'b1, e_cas2_n = 1'b1;
    logic       e_ra7 = 1'b0, e_wsreq_n = 1'b1;
    logic [7:0] e_rfcnt = 8'd0;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic bmreq_n, input logic brfsh_n, input logic brd_n,
                                 input logic n_bwr, input logic ramsel_n, input logic ba15,
                                 input logic ba7, input logic ba14, input logic bm1_n);
        bus.BMREQ_N  = bmreq_n;
        bus.BRFSH_N  = brfsh_n;
        bus.BRD_N    = brd_n;
        bus.N_BWR    = n_bwr;
        bus.RAMSEL_N = ramsel_n;
        bus.BA15     = ba15;
        bus.BA7      = ba7;
        bus.BA14     = ba14;
        bus.BM1_N    = bm1_n;
    endtask

    task automatic busIdle();
        applyStimulus(1, 1, 1, 1, 1, 0, 0, 0, 1);
    endtask

    task automatic stepEdge();
        @(posedge B_PHI);
        @(negedge B_PHI);
    endtask

    // Counts edges from now until RAS_N is seen low (bounded).
    task automatic edgesUntilRas(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            stepEdge();
            n++;
            if (bus.RAS_N == 1'b0) break;
        end
    endtask

    // Behavioural timeline: a request accepted at age 0 shows RAS from age 1,
    // the column phase from age TRCD+1, and CAS one edge after the first
    // column-phase edge with a read/write (one edge later for waited fetches).
    // A released request frees the bus TRP+1 edges later.
    always @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            m_acc = 0; m_rfsh = 0; m_age = 0; m_cas_at = -1;
            m_edge = 0; m_ready = 0;
            e_ras_n = 1; e_mux = 0; e_cas1_n = 1; e_cas2_n = 1;
            e_ra7 = 0; e_wsreq_n = 1; e_rfcnt = 8'd0;
        end else begin
            m_edge++;
            e_ras_n = 1; e_mux = 0; e_cas1_n = 1; e_cas2_n = 1;
            e_ra7 = 0; e_wsreq_n = 1;
            if (m_acc || m_rfsh) begin
                m_age++;
                if (bus.BMREQ_N) begin
                    if (m_rfsh) e_rfcnt = e_rfcnt + 8'd1;
                    m_acc = 0;
                    m_rfsh = 0;
                    m_ready = m_edge + TRP + 1;
                end else if (m_rfsh) begin
                    e_ras_n = 0;
                    e_ra7 = bus.BA7;
                end else begin
                    e_ras_n = 0;
                    if (m_age <= TRCD) begin
                        e_ra7 = bus.BA7;
                    end else begin
                        e_mux = 1;
                        e_ra7 = bus.BA14;
                        if (m_cas_at >= 0) begin
                            if (m_bank) e_cas2_n = 0;
                            else        e_cas1_n = 0;
                        end else if (WAIT_EN && m_m1 && m_age == TRCD + 1) begin
                            e_wsreq_n = 0;
                        end else if (!bus.BRD_N || !bus.N_BWR) begin
                            m_cas_at = m_age;
                        end
                    end
                end
            end else if (m_edge >= m_ready && !bus.BMREQ_N && (!bus.BRFSH_N || !bus.RAMSEL_N)) begin
                m_rfsh = !bus.BRFSH_N;
                m_acc = bus.BRFSH_N;
                m_age = 0;
                m_bank = bus.BA15;
                m_m1 = !bus.BM1_N;
                m_cas_at = -1;
            end
        end
    end

    // Per-cycle comparison against the model, plus the strobe safety rules.
    always @(negedge B_PHI) begin
        if (check_en) begin
            checkOutput("RAS_N", bus.RAS_N, e_ras_n);
            checkOutput("MUX", bus.MUX, e_mux);
            checkOutput("CAS1_N", bus.CAS1_N, e_cas1_n);
            checkOutput("CAS2_N", bus.CAS2_N, e_cas2_n);
            checkOutput("RA7", bus.RA7, e_ra7);
            checkOutput("RFCNT", bus.RFCNT, e_rfcnt);
`ifdef MIOC_DRAM_WAIT_EN
            checkOutput("WSREQ_N", bus.WSREQ_N, e_wsreq_n);
`endif
            checkOutput("cas_overlap", {7'b0, !bus.CAS1_N && !bus.CAS2_N}, 8'd0);
            checkOutput("cas_without_ras", {7'b0, (!bus.CAS1_N || !bus.CAS2_N) && bus.RAS_N}, 8'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        logic bmreq;

        RST_N = 1'b0;
        busIdle();
        repeat (2) @(negedge B_PHI);
        #1;
        checkOutput("rst_ras", bus.RAS_N, 1);
        checkOutput("rst_mux", bus.MUX, 0);
        checkOutput("rst_cas1", bus.CAS1_N, 1);
        checkOutput("rst_cas2", bus.CAS2_N, 1);
        checkOutput("rst_ra7", bus.RA7, 0);
        checkOutput("rst_rfcnt", bus.RFCNT, 0);
`ifdef MIOC_DRAM_WAIT_EN
        checkOutput("rst_wsreq", bus.WSREQ_N, 1);
`endif
        @(negedge B_PHI);
        RST_N = 1'b1;
        check_en = 1'b1;
        stepEdge();

        // Read, bank 0, BA7=1 BA14=0.
        applyStimulus(0, 1, 0, 1, 0, 0, 1, 0, 1);
        stepEdge();
        checkOutput("rd_e0_ras", bus.RAS_N, 1);
        stepEdge();
        checkOutput("rd_e1_ras", bus.RAS_N, 0);
        checkOutput("rd_e1_ra7", bus.RA7, 1);
        checkOutput("rd_e1_mux", bus.MUX, 0);
        stepEdge();
        checkOutput("rd_e2_mux", bus.MUX, 1);
        checkOutput("rd_e2_ra7", bus.RA7, 0);
        checkOutput("rd_e2_cas1", bus.CAS1_N, 1);
        stepEdge();
        checkOutput("rd_e3_cas1", bus.CAS1_N, 0);
        checkOutput("rd_e3_cas2", bus.CAS2_N, 1);
        stepEdge();
        stepEdge();
        bus.BMREQ_N = 1'b1;
        stepEdge();
        checkOutput("rd_e6_ras", bus.RAS_N, 1);
        checkOutput("rd_e6_cas1", bus.CAS1_N, 1);
        checkOutput("rd_e6_mux", bus.MUX, 0);

        // Back-to-back write to bank 1 right after release.
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 1, 1);
        edgesUntilRas(n);
        checkOutput("b2b_gap", 8'(n), 8'd4);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            stepEdge();
            checkOutput("wr_cas1_high", bus.CAS1_N, 1);
            if (!bus.CAS2_N) seen = 1;
        end
        checkOutput("wr_cas2_seen", {7'b0, seen}, 8'd1);
        bus.BMREQ_N = 1'b1;
        stepEdge();
        checkOutput("wr_rel_cas2", bus.CAS2_N, 1);
        repeat (4) stepEdge();

        // Abort while waiting in the column phase.
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            stepEdge();
            if (!bus.CAS1_N || !bus.CAS2_N) seen = 1;
        end
        checkOutput("abort_mux", bus.MUX, 1);
        bus.BMREQ_N = 1'b1;
        stepEdge();
        checkOutput("abort_ras", bus.RAS_N, 1);
        checkOutput("abort_no_cas", {7'b0, seen}, 8'd0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 1);
        edgesUntilRas(n);
        checkOutput("abort_gap", 8'(n), 8'd4);
        bus.BMREQ_N = 1'b1;
        stepEdge();
        repeat (4) stepEdge();

        // Refresh (RAMSEL_N high: refresh does not need a DRAM select).
        checkOutput("rf_cnt0", bus.RFCNT, 0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, 1);
        stepEdge();
        stepEdge();
        checkOutput("rf_ras", bus.RAS_N, 0);
        checkOutput("rf_cas1", bus.CAS1_N, 1);
        checkOutput("rf_cas2", bus.CAS2_N, 1);
        bus.BMREQ_N = 1'b1;
        stepEdge();
        checkOutput("rf_cnt1", bus.RFCNT, 1);
        repeat (3) stepEdge();
        for (int i = 0; i < 255; i++) begin
            applyStimulus(0, 0, 1, 1, 1, 0, 0, 0, 1);
            repeat (2) stepEdge();
            bus.BMREQ_N = 1'b1;
            repeat (4) stepEdge();
        end
        checkOutput("rf_wrap", bus.RFCNT, 0);

        // Asynchronous reset in the middle of CAS.
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 1);
        repeat (4) stepEdge();
        checkOutput("ar_cas_low", bus.CAS1_N, 0);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("ar_cas1", bus.CAS1_N, 1);
        checkOutput("ar_ras", bus.RAS_N, 1);
        checkOutput("ar_mux", bus.MUX, 0);
        busIdle();
        #1 RST_N = 1'b1;
        @(negedge B_PHI);
        stepEdge();

`ifdef MIOC_DRAM_WAIT_EN
        // Opcode fetch: one wait cycle, CAS one edge later.
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);
        repeat (3) stepEdge();
        checkOutput("ws_e2_wsreq", bus.WSREQ_N, 0);
        stepEdge();
        checkOutput("ws_e3_wsreq", bus.WSREQ_N, 1);
        checkOutput("ws_e3_cas1", bus.CAS1_N, 1);
        stepEdge();
        checkOutput("ws_e4_cas1", bus.CAS1_N, 0);
        bus.BMREQ_N = 1'b1;
        repeat (4) stepEdge();
`endif

        // Randomized traffic against the model.
        bmreq = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 5) == 0) bmreq = !bmreq;
            applyStimulus(bmreq,
                          ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 399) == 0) begin
                #2 RST_N = 1'b0;
                #2 RST_N = 1'b1;
            end
            @(negedge B_PHI);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
